// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    // Index of the set bit in a one-hot mask (up to 16 requesters).
    // The result is 0 when the mask is all zero.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

    // Rotate the low n bits of m left by sh positions; bits at n and above are cleared.
    function automatic logic [15:0] rotl(input logic [15:0] m, input int unsigned sh,
                                         input int unsigned n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(n)) r[(i + int'(sh)) % int'(n)] = m[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr, circularly.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [PW-1:0]    o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_hit;
    logic               w_found;

    // Search the doubled request vector from i_ptr upward. The window ptr..ptr+N-1
    // always contains every requester once, so the wrap falls out of the doubling.
    always_comb begin
        w_dbl   = {i_req, i_req};
        w_hit   = '0;
        w_found = 1'b0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (!w_found && w_dbl[i] && (i >= int'(i_ptr))) begin
                w_hit[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign o_onehot = w_hit[N_REQ-1:0] | w_hit[2*N_REQ-1:N_REQ];
    assign o_idx    = PW'(onehot_to_idx(16'(o_onehot)));
    assign o_any    = |i_req;

endmodule

// File: rtl/rr_arb_locked.sv
// Round-robin arbiter sharing one valid/ready stream; a grant is held for a whole packet.
module rr_arb_locked
    import arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_out_valid,
    output logic [DATA_W-1:0]       o_out_data,
    output logic                    o_out_last,
    input  logic                    i_out_ready,
    output logic [N_REQ-1:0]        o_gnt,
    output logic                    o_busy
);

    arb_state_t        r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_idx;
    logic [N_REQ-1:0]  r_gnt;

    logic [N_REQ-1:0]  w_pick_oh;
    logic [PW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic              w_locked;
    logic              w_gvalid;
    logic              w_glast;
    logic [DATA_W-1:0] w_gdata;
    logic              w_release;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req    (i_req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_locked = (r_state == ARB_LOCKED);

    // Select the granted requester's beat; everything reads zero when not locked.
    always_comb begin
        w_gvalid = 1'b0;
        w_glast  = 1'b0;
        w_gdata  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_locked && (r_idx == PW'(i))) begin
                w_gvalid = i_req_valid[i];
                w_glast  = i_req_last[i];
                w_gdata  = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Lock ends only when the last beat is actually handed downstream.
    assign w_release = w_gvalid & w_glast & i_out_ready;

    // FSM, grant register and priority pointer; pointer moves past each winner.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_any) begin
                        r_state <= ARB_LOCKED;
                        r_gnt   <= w_pick_oh;
                        r_idx   <= w_pick_idx;
                        // Explicit wrap so non-power-of-two N_REQ never leaves the legal range.
                        r_ptr   <= (w_pick_idx == PW'(N_REQ-1)) ? '0 : w_pick_idx + PW'(1);
                    end
                end
                default: begin
                    if (w_release) begin
                        r_state <= ARB_IDLE;
                        r_gnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign o_out_valid = w_gvalid;
    assign o_out_data  = w_gdata;
    assign o_out_last  = w_gvalid & w_glast;
    assign o_req_ready = (w_locked && i_out_ready) ? r_gnt : '0;
    assign o_gnt       = r_gnt;
    assign o_busy      = w_locked;

endmodule
